// File: rtl/radix2_nonrestoring_divider_if.sv
// Handshake/data bundle between a requester and radix2_nonrestoring_divider.
// Requester side (master): start, dividend, divisor.
// Divider side (slave): busy, done, quotient, remainder, div_by_zero.
interface radix2_nonrestoring_divider_if #(
   parameter int n = 32
) ();
   logic         start;
   logic [n-1:0] dividend;
   logic [n-1:0] divisor;
   logic         busy;
   logic         done;
   logic [n-1:0] quotient;
   logic [n-1:0] remainder;
   logic         div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/radix2_nonrestoring_divider.sv
// Iterative signed n-bit divider, non-restoring, one quotient bit per clock.
// Latency: done pulses n+2 clocks after start is sampled (special cases included).
// Backpressure: none; start is only accepted while idle, otherwise ignored (no queueing).
// Ports: clk, rst (async active-low); bus (slave modport) carries start/dividend/divisor
// in and busy/done/quotient/remainder/div_by_zero out. Outputs hold until the next result.
module radix2_nonrestoring_divider #(
   parameter int n = 32
) (
   input logic                        clk,
   input logic                        rst,
   radix2_nonrestoring_divider_if.slave bus
);

   localparam int CW = $clog2(n + 1);

   typedef enum logic [1:0] {IDLE, CALC, FIX, OUT} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   logic [n:0]    p;        // signed partial remainder
   logic [n:0]    d;        // divisor magnitude
   logic [n-1:0]  q;        // dividend magnitude, shifted out as quotient bits shift in
   logic [n-1:0]  dvd;      // raw dividend, returned as remainder on divide-by-zero
   logic          sa, sb;   // operand signs
   logic          dz, ovf;  // special-case flags

   logic          ld, step, fix, fin;

   logic [n:0]    dvd_ext, dvs_ext, dvd_abs, dvs_abs;
   logic [n:0]    p_sh, p_step;
   logic [n-1:0]  q_sgn, r_sgn, min_neg;

   // Magnitudes in n+1 bits so that |-2^(n-1)| is representable.
   always_comb begin
      dvd_ext = {bus.dividend[n-1], bus.dividend};
      dvs_ext = {bus.divisor[n-1], bus.divisor};
      dvd_abs = dvd_ext[n] ? -dvd_ext : dvd_ext;
      dvs_abs = dvs_ext[n] ? -dvs_ext : dvs_ext;
   end

   // One non-restoring step: shift {P,Q}, then subtract or add D depending on
   // the sign of P before the shift.
   always_comb begin
      p_sh   = {p[n-1:0], q[n-1]};
      p_step = p[n] ? (p_sh + d) : (p_sh - d);
   end

   // Sign application; p is already corrected by the time this is used.
   always_comb begin
      min_neg = {1'b1, {(n-1){1'b0}}};
      q_sgn   = (sa ^ sb) ? -q : q;
      r_sgn   = sa ? -p[n-1:0] : p[n-1:0];
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = CALC;
         CALC:    if (cnt == CW'(1)) state_nxt = FIX;
         FIX:     state_nxt = OUT;
         OUT:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs / datapath strobes
   always_comb begin
      ld       = 1'b0;
      step     = 1'b0;
      fix      = 1'b0;
      fin      = 1'b0;
      bus.busy = (state != IDLE);
      case (state)
         IDLE:    ld   = bus.start;
         CALC:    step = 1'b1;
         FIX:     fix  = 1'b1;
         OUT:     fin  = 1'b1;
         default: ;
      endcase
   end

   // Datapath and registered results
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt             <= '0;
         p               <= '0;
         d               <= '0;
         q               <= '0;
         dvd             <= '0;
         sa              <= 1'b0;
         sb              <= 1'b0;
         dz              <= 1'b0;
         ovf             <= 1'b0;
         bus.done        <= 1'b0;
         bus.quotient    <= '0;
         bus.remainder   <= '0;
         bus.div_by_zero <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         if (ld) begin
            cnt <= CW'(n);
            p   <= '0;
            d   <= dvs_abs;
            q   <= dvd_abs[n-1:0];
            dvd <= bus.dividend;
            sa  <= bus.dividend[n-1];
            sb  <= bus.divisor[n-1];
            dz  <= (bus.divisor == '0);
            ovf <= (bus.dividend == {1'b1, {(n-1){1'b0}}}) && (bus.divisor == '1);
         end
         if (step) begin
            p   <= p_step;
            q   <= {q[n-2:0], ~p_step[n]};
            cnt <= cnt - CW'(1);
         end
         if (fix && p[n]) begin
            p <= p + d;
         end
         if (fin) begin
            bus.done        <= 1'b1;
            bus.div_by_zero <= dz;
            if (dz) begin
               bus.quotient  <= '1;
               bus.remainder <= dvd;
            end else if (ovf) begin
               bus.quotient  <= min_neg;
               bus.remainder <= '0;
            end else begin
               bus.quotient  <= q_sgn;
               bus.remainder <= r_sgn;
            end
         end
      end
   end

endmodule

// File: tb/tb_radix2_nonrestoring_divider.sv
// Scoreboard bench for radix2_nonrestoring_divider (n=32): directed operations push
// their expected result and start cycle; a monitor checks every done pulse.
module tb_radix2_nonrestoring_divider;
   localparam int N   = 32;
   localparam int LAT = N + 2;

   typedef struct {
      logic [N-1:0] q;
      logic [N-1:0] r;
      logic         dz;
      int           scyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   int   pushed = 0;
   int   popped = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   radix2_nonrestoring_divider_if #(.n(N)) bus ();

   radix2_nonrestoring_divider #(.n(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp_v, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (bus.done === 1'b1) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: done=1 with no operation outstanding (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            popped++;
            chk("quotient", bus.quotient, e.q);
            chk("remainder", bus.remainder, e.r);
            chk("div_by_zero", {{(N-1){1'b0}}, bus.div_by_zero}, {{(N-1){1'b0}}, e.dz});
            chk("latency", N'(cyc - e.scyc), N'(LAT));
            chk("busy_in_done", {{(N-1){1'b0}}, bus.busy}, '0);
         end
      end
   end

   // Wait (bounded) for an idle negedge, then present start for one edge.
   task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
      int n_wait;
      n_wait = 0;
      @(negedge clk);
      while (bus.busy === 1'b1 && n_wait < 100) begin
         @(negedge clk);
         n_wait++;
      end
      if (bus.busy === 1'b1) begin
         checks++;
         errors++;
         $display("FAIL busy_timeout: busy stuck high (cycle %0d)", cyc);
      end
      bus.start    = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] eq, input logic [N-1:0] er, input logic edz);
      exp_t e;
      issue(a, b);
      e.q    = eq;
      e.r    = er;
      e.dz   = edz;
      e.scyc = cyc;
      sb_q.push_back(e);
      pushed++;
   endtask

   task automatic drain();
      int n_wait;
      n_wait = 0;
      while (sb_q.size() != 0 && n_wait < 200) begin
         @(negedge clk);
         n_wait++;
      end
      if (sb_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: %0d operations never completed", sb_q.size());
      end
   endtask

   initial begin
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", {{(N-1){1'b0}}, bus.busy}, '0);
      chk("reset_done", {{(N-1){1'b0}}, bus.done}, '0);
      chk("reset_quotient", bus.quotient, '0);
      chk("reset_remainder", bus.remainder, '0);
      chk("reset_dz", {{(N-1){1'b0}}, bus.div_by_zero}, '0);
      rst = 1'b1;
      repeat (2) @(posedge clk);

      // Sign combinations
      do_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
      chk("busy_after_start", {{(N-1){1'b0}}, bus.busy}, 32'd1);
      do_op(-32'sd100, 32'd7, -32'sd14, -32'sd2, 1'b0);
      do_op(32'd100, -32'sd7, -32'sd14, 32'd2, 1'b0);
      do_op(-32'sd100, -32'sd7, 32'd14, -32'sd2, 1'b0);

      // Divide by zero, then a normal op clears the flag
      do_op(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
      do_op(32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
      do_op(-32'sd7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1);
      do_op(32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);

      // Width extremes
      do_op(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
      do_op(32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 32'd0, 1'b0);
      do_op(32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0);
      do_op(32'd3, 32'h8000_0000, 32'd0, 32'd3, 1'b0);

      // Start while busy is ignored; then start held in the done cycle
      do_op(32'd50, 32'd5, 32'd10, 32'd0, 1'b0);
      repeat (9) @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = 32'd7;
      bus.divisor  = 32'd7;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      do_op(32'd7, 32'd7, 32'd1, 32'd0, 1'b0);
      do_op(32'd23, 32'd5, 32'd4, 32'd3, 1'b0);
      drain();

      // Asynchronous reset mid-operation: outputs clear at once, no done follows
      issue(32'd100, 32'd7);
      repeat (15) @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("abort_busy", {{(N-1){1'b0}}, bus.busy}, '0);
      chk("abort_done", {{(N-1){1'b0}}, bus.done}, '0);
      chk("abort_quotient", bus.quotient, '0);
      chk("abort_remainder", bus.remainder, '0);
      chk("abort_dz", {{(N-1){1'b0}}, bus.div_by_zero}, '0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (40) @(posedge clk);
      do_op(32'd0, 32'd3, 32'd0, 32'd0, 1'b0);
      drain();

      repeat (3) @(posedge clk);
      chk("done_count", N'(popped), N'(pushed));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
